// File: rtl/glb_port_scheduler_if.sv
// GLB-side bus of the port scheduler: command and read-return.
// master drives glb_req/addr/web and rd_valid/class/id; slave observes.
interface glb_port_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 5
);
  logic              glb_req_o;
  logic [ADDR_W-1:0] glb_addr_o;
  logic [3:0]        glb_web_o;
  logic              rd_valid_o;
  logic [1:0]        rd_class_o;
  logic [ID_W-1:0]   rd_id_o;

  modport master (
    output glb_req_o, glb_addr_o, glb_web_o,
    output rd_valid_o, rd_class_o, rd_id_o
  );
  modport slave (
    input glb_req_o, glb_addr_o, glb_web_o,
    input rd_valid_o, rd_class_o, rd_id_o
  );
endinterface

// File: rtl/glb_port_scheduler.sv
// Round-robin scheduler for the single GLB SRAM port (ifmap/ipsum rd, opsum wr).
// Ports: clk, rst, sched_en_i, glb_busy_i, per-FIFO req/addr/web in, grants out, glb bus.
module glb_port_scheduler #(
  parameter int N_IF   = 32,
  parameter int N_IP   = 32,
  parameter int N_OP   = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1,
  parameter int ID_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sched_en_i,
  input  logic                   glb_busy_i,
  input  logic [N_IF-1:0]        ifmap_req_i,
  input  logic [N_IF*ADDR_W-1:0] ifmap_addr_i,
  input  logic [N_IP-1:0]        ipsum_req_i,
  input  logic [N_IP*ADDR_W-1:0] ipsum_addr_i,
  input  logic [N_OP-1:0]        opsum_req_i,
  input  logic [N_OP*ADDR_W-1:0] opsum_addr_i,
  input  logic [N_OP*4-1:0]      opsum_web_i,
  input  logic                   opsum_urgent_i,
  output logic [N_IF-1:0]        ifmap_grant_o,
  output logic [N_IP-1:0]        ipsum_grant_o,
  output logic [N_OP-1:0]        opsum_grant_o,
  glb_port_scheduler_if.master   glb
);

  localparam int N_M1  = (N_IF > N_IP) ? N_IF : N_IP;
  localparam int N_MAX = (N_M1 > N_OP) ? N_M1 : N_OP;

  typedef enum logic [1:0] {
    C_IF = 2'd0,
    C_IP = 2'd1,
    C_OP = 2'd2
  } cls_e;

  // Returns {found, idx}: first set bit at or after ptr, wrapping at n.
  function automatic logic [ID_W:0] rr_pick(
    input logic [N_MAX-1:0] el,
    input int               ptr,
    input int               n
  );
    logic            found;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] jj;
    int              j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_MAX; k++) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        jj = ID_W'(j);
        if (!found && el[jj]) begin
          found = 1'b1;
          idx   = jj;
        end
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [ID_W-1:0] nxt(
    input logic [ID_W-1:0] idx,
    input int              n
  );
    int t;
    t = int'(idx) + 1;
    if (t >= n) t = 0;
    return ID_W'(t);
  endfunction

  logic [ID_W-1:0]   ptr_if_q, ptr_if_d;
  logic [ID_W-1:0]   ptr_ip_q, ptr_ip_d;
  logic [ID_W-1:0]   ptr_op_q, ptr_op_d;
  cls_e              cls_q, cls_d;
  logic [N_IF-1:0]   gif_q, gif_d;
  logic [N_IP-1:0]   gip_q, gip_d;
  logic [N_OP-1:0]   gop_q, gop_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        web_q, web_d;
  logic [1:0]        icls_q, icls_d;
  logic [ID_W-1:0]   iid_q, iid_d;
  logic              tv_q [RD_LAT];
  logic              tv_d [RD_LAT];
  logic [1:0]        tc_q [RD_LAT];
  logic [1:0]        tc_d [RD_LAT];
  logic [ID_W-1:0]   ti_q [RD_LAT];
  logic [ID_W-1:0]   ti_d [RD_LAT];

  logic [ID_W:0]   pk_if, pk_ip, pk_op;
  logic            any_if, any_ip, any_op;
  logic            urg, win_ok, avail, grant;
  cls_e            win;
  logic [ID_W-1:0] widx;
  logic            trd;
  int              c;

  always_comb begin
    // A requester granted last cycle sits out this cycle.
    pk_if  = rr_pick(N_MAX'(ifmap_req_i & ~gif_q),
                     int'(ptr_if_q), N_IF);
    pk_ip  = rr_pick(N_MAX'(ipsum_req_i & ~gip_q),
                     int'(ptr_ip_q), N_IP);
    pk_op  = rr_pick(N_MAX'(opsum_req_i & ~gop_q),
                     int'(ptr_op_q), N_OP);
    any_if = pk_if[ID_W];
    any_ip = pk_ip[ID_W];
    any_op = pk_op[ID_W];
    urg    = opsum_urgent_i && any_op;
    win_ok = urg;
    win    = urg ? C_OP : C_IF;
    avail  = 1'b0;
    c      = 0;
    for (int k = 0; k < 3; k++) begin
      c = int'(cls_q) + k;
      if (c >= 3) c = c - 3;
      avail = (c == 0) ? any_if :
              (c == 1) ? any_ip : any_op;
      if (!win_ok && avail) begin
        win_ok = 1'b1;
        win    = cls_e'(c[1:0]);
      end
    end
    grant = win_ok && sched_en_i && !glb_busy_i;
    widx  = (win == C_IF) ? pk_if[ID_W-1:0] :
            (win == C_IP) ? pk_ip[ID_W-1:0] :
                            pk_op[ID_W-1:0];

    ptr_if_d = ptr_if_q;
    ptr_ip_d = ptr_ip_q;
    ptr_op_d = ptr_op_q;
    cls_d    = cls_q;
    gif_d    = '0;
    gip_d    = '0;
    gop_d    = '0;
    req_d    = 1'b0;
    addr_d   = addr_q;
    web_d    = 4'hF;
    icls_d   = icls_q;
    iid_d    = iid_q;

    if (grant) begin
      req_d  = 1'b1;
      icls_d = win;
      iid_d  = widx;
      unique case (1'b1)
        (win == C_IF): begin
          gif_d[widx] = 1'b1;
          addr_d   = ifmap_addr_i[int'(widx)*ADDR_W +: ADDR_W];
          ptr_if_d = nxt(widx, N_IF);
          cls_d    = C_IP;
        end
        (win == C_IP): begin
          gip_d[widx] = 1'b1;
          addr_d   = ipsum_addr_i[int'(widx)*ADDR_W +: ADDR_W];
          ptr_ip_d = nxt(widx, N_IP);
          cls_d    = C_OP;
        end
        default: begin
          gop_d[widx] = 1'b1;
          addr_d   = opsum_addr_i[int'(widx)*ADDR_W +: ADDR_W];
          web_d    = opsum_web_i[int'(widx)*4 +: 4];
          ptr_op_d = nxt(widx, N_OP);
          // Urgent service leaves the normal rotation untouched.
          cls_d    = urg ? cls_q : C_IF;
        end
      endcase
    end

    // Tag pipe is fed from the issued command, so stage RD_LAT-1
    // lines up with the SRAM data RD_LAT cycles after glb_req_o.
    trd   = req_q && (icls_q != C_OP);
    tv_d[0] = trd;
    tc_d[0] = trd ? icls_q : 2'd0;
    ti_d[0] = trd ? iid_q : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      tv_d[i] = tv_q[i-1];
      tc_d[i] = tc_q[i-1];
      ti_d[i] = ti_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_if_q <= '0;
      ptr_ip_q <= '0;
      ptr_op_q <= '0;
      cls_q    <= C_IF;
      gif_q    <= '0;
      gip_q    <= '0;
      gop_q    <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      web_q    <= 4'hF;
      icls_q   <= 2'd0;
      iid_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tv_q[i] <= 1'b0;
        tc_q[i] <= 2'd0;
        ti_q[i] <= '0;
      end
    end else begin
      ptr_if_q <= ptr_if_d;
      ptr_ip_q <= ptr_ip_d;
      ptr_op_q <= ptr_op_d;
      cls_q    <= cls_d;
      gif_q    <= gif_d;
      gip_q    <= gip_d;
      gop_q    <= gop_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      web_q    <= web_d;
      icls_q   <= icls_d;
      iid_q    <= iid_d;
      for (int i = 0; i < RD_LAT; i++) begin
        tv_q[i] <= tv_d[i];
        tc_q[i] <= tc_d[i];
        ti_q[i] <= ti_d[i];
      end
    end
  end

  assign ifmap_grant_o  = gif_q;
  assign ipsum_grant_o  = gip_q;
  assign opsum_grant_o  = gop_q;
  assign glb.glb_req_o  = req_q;
  assign glb.glb_addr_o = addr_q;
  assign glb.glb_web_o  = web_q;
  assign glb.rd_valid_o = tv_q[RD_LAT-1];
  assign glb.rd_class_o = tc_q[RD_LAT-1];
  assign glb.rd_id_o    = ti_q[RD_LAT-1];

endmodule

// File: tb/tb_glb_port_scheduler.sv
// Bench for glb_port_scheduler: vector table plus scoreboarded sequences.
// Grants and read returns are checked against bench-side queues.
module tb_glb_port_scheduler;
  localparam int N  = 32;
  localparam int AW = 32;
  localparam int RL = 2;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sched_en = 1'b1;
  logic busy = 1'b0;
  logic urgent = 1'b0;
  logic [N-1:0]    ifr = '0, ipr = '0, opr = '0;
  logic [N*AW-1:0] ifa = '0, ipa = '0, opa = '0;
  logic [N*4-1:0]  opw = '1;
  logic [N-1:0]    ifg, ipg, opg;

  always #5 clk = ~clk;

  glb_port_scheduler_if #(.ADDR_W(AW), .ID_W(IW)) gif ();

  glb_port_scheduler #(
    .N_IF(N), .N_IP(N), .N_OP(N),
    .ADDR_W(AW), .RD_LAT(RL), .ID_W(IW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sched_en_i     (sched_en),
    .glb_busy_i     (busy),
    .ifmap_req_i    (ifr),
    .ifmap_addr_i   (ifa),
    .ipsum_req_i    (ipr),
    .ipsum_addr_i   (ipa),
    .opsum_req_i    (opr),
    .opsum_addr_i   (opa),
    .opsum_web_i    (opw),
    .opsum_urgent_i (urgent),
    .ifmap_grant_o  (ifg),
    .ipsum_grant_o  (ipg),
    .opsum_grant_o  (opg),
    .glb            (gif)
  );

  typedef struct {
    logic [1:0]  cls;
    int          id;
    logic [31:0] addr;
    logic [3:0]  web;
  } gexp_t;

  typedef struct {
    int         due;
    logic [1:0] cls;
    int         id;
  } rexp_t;

  typedef struct {
    logic [1:0]  cls;
    int          id;
    logic [31:0] addr;
    logic [3:0]  web;
    bit          en;
    bit          bsy;
    bit          expg;
  } vec_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    cyc = 0;
  int    nvec = 0;
  int    nerr = 0;
  bit    mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    int    ng;
    int    ac;
    int    ai;
    gexp_t e;
    rexp_t r;
    if (mon_on) begin
      ng = $countones({ifg, ipg, opg});
      chk("onehot", 64'(ng), 64'(gif.glb_req_o ? 1 : 0));
      if (gif.glb_req_o) begin
        ac = 3;
        ai = 0;
        for (int i = 0; i < N; i++) begin
          if (ifg[i]) begin ac = 0; ai = i; end
          if (ipg[i]) begin ac = 1; ai = i; end
          if (opg[i]) begin ac = 2; ai = i; end
        end
        nvec++;
        if (gq.size() == 0) begin
          nerr++;
          $display("FAIL grant: unexpected cls %0d id %0d", ac, ai);
        end else begin
          e = gq.pop_front();
          if (ac != int'(e.cls) || ai != e.id ||
              gif.glb_addr_o !== e.addr ||
              gif.glb_web_o !== e.web) begin
            nerr++;
            $display("FAIL grant: got c%0d i%0d a%0h w%0h want c%0d i%0d a%0h w%0h",
                     ac, ai, gif.glb_addr_o, gif.glb_web_o,
                     e.cls, e.id, e.addr, e.web);
          end
          if (e.cls != 2'd2)
            rq.push_back('{cyc + RL, e.cls, e.id});
        end
      end
      if (gif.rd_valid_o) begin
        nvec++;
        if (rq.size() == 0) begin
          nerr++;
          $display("FAIL rdback: unexpected rd_valid c%0d i%0d",
                   gif.rd_class_o, gif.rd_id_o);
        end else begin
          r = rq.pop_front();
          if (r.due != cyc || gif.rd_class_o !== r.cls ||
              int'(gif.rd_id_o) != r.id) begin
            nerr++;
            $display("FAIL rdback: got cyc%0d c%0d i%0d want cyc%0d c%0d i%0d",
                     cyc, gif.rd_class_o, gif.rd_id_o,
                     r.due, r.cls, r.id);
          end
        end
      end else if (rq.size() != 0 && rq[0].due == cyc) begin
        nvec++;
        nerr++;
        $display("FAIL rdback: missing rd_valid got 0 want c%0d i%0d",
                 rq[0].cls, rq[0].id);
        void'(rq.pop_front());
      end
    end
  end

  task automatic do_reset();
    mon_on = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    gq.delete();
    rq.delete();
    chk("rst_req", 64'(gif.glb_req_o), 64'd0);
    chk("rst_addr", 64'(gif.glb_addr_o), 64'd0);
    chk("rst_web", 64'(gif.glb_web_o), 64'hF);
    chk("rst_rdv", 64'(gif.rd_valid_o), 64'd0);
    chk("rst_rdc", 64'(gif.rd_class_o), 64'd0);
    chk("rst_rdi", 64'(gif.rd_id_o), 64'd0);
    chk("rst_gnt", 64'($countones({ifg, ipg, opg})), 64'd0);
    mon_on = 1'b1;
  endtask

  task automatic set_addrs();
    for (int i = 0; i < N; i++) begin
      ifa[i*AW +: AW] = 32'h1000 + 32'(i * 4);
      ipa[i*AW +: AW] = 32'h2000 + 32'(i * 4);
      opa[i*AW +: AW] = 32'h3000 + 32'(i * 4);
      opw[i*4 +: 4]   = 4'h0;
    end
  endtask

  task automatic pexp(logic [1:0] c, int id, logic [31:0] a, logic [3:0] w);
    gq.push_back('{c, id, a, w});
  endtask

  task automatic hold(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ifr = '0; ipr = '0; opr = '0;
    urgent = 1'b0; busy = 1'b0; sched_en = 1'b1;
  endtask

  task automatic drain();
    hold(RL + 3);
    chk("gq_empty", 64'(gq.size()), 64'd0);
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{2'd0,  3, 32'h0000_0100, 4'hF, 1'b1, 1'b0, 1'b1};
    vt[1] = '{2'd1,  0, 32'h0000_0200, 4'hF, 1'b1, 1'b0, 1'b1};
    vt[2] = '{2'd1, 31, 32'h0000_02F0, 4'hF, 1'b1, 1'b0, 1'b1};
    vt[3] = '{2'd2,  7, 32'h0000_0400, 4'h0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{2'd2, 31, 32'hFFFF_FFFC, 4'hA, 1'b1, 1'b0, 1'b1};
    vt[5] = '{2'd0, 31, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 1'b1};
    vt[6] = '{2'd0,  0, 32'h0000_0008, 4'hF, 1'b0, 1'b0, 1'b0};
    vt[7] = '{2'd1,  5, 32'h0000_0010, 4'hF, 1'b1, 1'b1, 1'b0};
    vt[8] = '{2'd0,  0, 32'h0000_ABC0, 4'hF, 1'b1, 1'b0, 1'b1};
    vt[9] = '{2'd2,  0, 32'h0000_0044, 4'h5, 1'b1, 1'b0, 1'b1};

    hold(2);
    do_reset();

    for (int v = 0; v < 10; v++) begin
      @(posedge clk);
      #1;
      unique case (vt[v].cls)
        2'd0: begin
          ifr[vt[v].id] = 1'b1;
          ifa[vt[v].id*AW +: AW] = vt[v].addr;
        end
        2'd1: begin
          ipr[vt[v].id] = 1'b1;
          ipa[vt[v].id*AW +: AW] = vt[v].addr;
        end
        default: begin
          opr[vt[v].id] = 1'b1;
          opa[vt[v].id*AW +: AW] = vt[v].addr;
          opw[vt[v].id*4 +: 4] = vt[v].web;
        end
      endcase
      sched_en = vt[v].en;
      busy = vt[v].bsy;
      if (vt[v].expg)
        pexp(vt[v].cls, vt[v].id, vt[v].addr,
             (vt[v].cls == 2'd2) ? vt[v].web : 4'hF);
      hold(1);
      clr();
      if (!vt[v].expg)
        chk($sformatf("idle_v%0d", v), 64'(gif.glb_req_o), 64'd0);
      drain();
    end

    // All 32 ifmap FIFOs requesting: 0..31 then wrap to 0.
    do_reset();
    set_addrs();
    for (int i = 0; i < 33; i++)
      pexp(2'd0, i % 32, 32'h1000 + 32'((i % 32) * 4), 4'hF);
    ifr = '1;
    hold(33);
    clr();
    drain();

    // Port busy for 3 cycles after grant 4.
    do_reset();
    set_addrs();
    for (int i = 0; i < 7; i++)
      pexp(2'd0, i, 32'h1000 + 32'(i * 4), 4'hF);
    ifr = '1;
    hold(5);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hold(1);
      chk($sformatf("busy_idle%0d", i), 64'(gif.glb_req_o), 64'd0);
    end
    busy = 1'b0;
    hold(2);
    clr();
    drain();

    // Class rotation ifmap -> ipsum -> opsum.
    do_reset();
    set_addrs();
    opa[7*AW +: AW] = 32'h400;
    opw[7*4 +: 4] = 4'h0;
    for (int r = 0; r < 2; r++) begin
      pexp(2'd0, 0, 32'h1000, 4'hF);
      pexp(2'd1, 5, 32'h2014, 4'hF);
      pexp(2'd2, 7, 32'h400, 4'h0);
    end
    ifr[0] = 1'b1; ipr[5] = 1'b1; opr[7] = 1'b1;
    hold(6);
    clr();
    drain();

    // Urgent opsum: 7/9 alternate, then rotation resumes at ifmap.
    do_reset();
    set_addrs();
    opa[7*AW +: AW] = 32'h400;
    opw[7*4 +: 4] = 4'h0;
    opa[9*AW +: AW] = 32'h900;
    opw[9*4 +: 4] = 4'h3;
    for (int r = 0; r < 2; r++) begin
      pexp(2'd2, 7, 32'h400, 4'h0);
      pexp(2'd2, 9, 32'h900, 4'h3);
    end
    pexp(2'd0, 0, 32'h1000, 4'hF);
    pexp(2'd1, 5, 32'h2014, 4'hF);
    pexp(2'd2, 7, 32'h400, 4'h0);
    ifr[0] = 1'b1; ipr[5] = 1'b1;
    opr[7] = 1'b1; opr[9] = 1'b1;
    urgent = 1'b1;
    hold(4);
    urgent = 1'b0;
    hold(3);
    clr();
    drain();

    // Reset while an ipsum read is in flight.
    do_reset();
    set_addrs();
    pexp(2'd1, 2, 32'h2008, 4'hF);
    ipr[2] = 1'b1;
    hold(1);
    ipr = '0;
    chk("t6_req", 64'(gif.glb_req_o), 64'd1);
    chk("t6_gnt", 64'(ipg), 64'd4);
    hold(1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t6_nordv%0d", i), 64'(gif.rd_valid_o), 64'd0);
    end
    @(posedge clk);
    #1;
    pexp(2'd0, 0, 32'h1000, 4'hF);
    pexp(2'd1, 0, 32'h2000, 4'hF);
    ifr = '1; ipr = '1;
    hold(2);
    clr();
    drain();
    chk("rq_empty", 64'(rq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
